pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives write-enable and flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Resolves three conditions:
  - load-use hazards (ID vs EX),
  - taken branches resolved in MEM from the EX/MEM zero flag,
  - multi-cycle data-memory accesses.
- Includes a memory-wait timeout watchdog and saturating stall/flush performance counters.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 35 +++
 rtl/pipe_hazard_ctrl_sat_counter.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Provides the FSM state encoding, the hard-wired zero register index,
// default parameter values and the packed control-output bundle with its
// fixed patterns.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_CNT_W   = 16;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_write;
        logic exmem_flush;
        logic memwb_flush;
        logic pc_sel_branch;
    } ctrl_t;

    // Bit order follows the struct: pw, iw, iff, idf, ew, ef, mf, psb.
    localparam ctrl_t CTRL_IDLE     = ctrl_t'(8'b0000_0000);
    localparam ctrl_t CTRL_NORMAL   = ctrl_t'(8'b1100_1000);
    localparam ctrl_t CTRL_LOAD_USE = ctrl_t'(8'b0001_1000);
    localparam ctrl_t CTRL_BRANCH   = ctrl_t'(8'b1111_1101);
    localparam ctrl_t CTRL_MEM_STALL = ctrl_t'(8'b0000_0010);

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Ports:
//   clk   - clock
//   rst   - asynchronous active-low reset (clears count)
//   inc   - increment by one this cycle (ignored once at all-ones)
//   clear - synchronous clear, dominates inc
//   cnt   - current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards (ID vs EX), taken branches resolved in MEM and
// multi-cycle data-memory accesses, with a memory-wait watchdog that freezes
// the pipeline in a sticky error state.
// Ports:
//   clk, rst                - clock, asynchronous active-low reset
//   id_rs, id_rt            - source registers of the instruction in ID
//   ex_mem_read, ex_rt      - load in EX and its destination register
//   mem_branch, mem_zero    - branch in MEM and its EX/MEM zero flag
//   mem_req, dmem_ready     - data-memory access in MEM and its completion
//   pc_write .. memwb_flush - pipeline register enables / flushes
//   pc_sel_branch           - steer branch target into PC
//   err                     - sticky memory-timeout error
//   stall_cnt, flush_cnt    - saturating performance counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_sel_branch,
    output logic             err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // wait_cnt counts the stall cycle that entered MEM_WAIT as 1; the
    // transition to ERR fires on the cycle that would bring it to TIMEOUT.
    localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

    state_t      state, state_n;
    logic [15:0] wait_cnt, wait_n;
    logic        err_r, err_n;
    ctrl_t       ctrl;
    logic        stall_inc, flush_inc;

    logic mem_stall, branch_taken, load_use;

    // mem_req gates dmem_ready so an unknown ready with no request is no stall.
    assign mem_stall    = mem_req & ~dmem_ready;
    assign branch_taken = mem_branch & mem_zero;
    assign load_use     = ex_mem_read & (ex_rt != REG_ZERO) &
                          ((ex_rt == id_rs) | (ex_rt == id_rt));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            err_r    <= 1'b0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_n;
            err_r    <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        wait_n    = wait_cnt;
        err_n     = err_r;
        ctrl      = CTRL_IDLE;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl      = CTRL_MEM_STALL;
                    state_n   = MEM_WAIT;
                    wait_n    = 16'd1;
                    stall_inc = 1'b1;
                end else if (branch_taken) begin
                    ctrl      = CTRL_BRANCH;
                    flush_inc = 1'b1;
                end else if (load_use) begin
                    ctrl      = CTRL_LOAD_USE;
                    stall_inc = 1'b1;
                end else begin
                    ctrl      = CTRL_NORMAL;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    ctrl    = CTRL_NORMAL;
                    state_n = RUN;
                    wait_n  = '0;
                end else begin
                    ctrl      = CTRL_MEM_STALL;
                    stall_inc = 1'b1;
                    wait_n    = wait_cnt + 16'd1;
                    if (wait_cnt >= TIMEOUT_M1) begin
                        state_n = ERR;
                        err_n   = 1'b1;
                    end
                end
            end
            ERR: begin
                ctrl = CTRL_IDLE;
            end
            default: begin
                state_n = RUN;
                wait_n  = '0;
            end
        endcase
        if (!rst) begin
            ctrl = CTRL_IDLE;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign ifid_write    = ctrl.ifid_write;
    assign ifid_flush    = ctrl.ifid_flush;
    assign idex_flush    = ctrl.idex_flush;
    assign exmem_write   = ctrl.exmem_write;
    assign exmem_flush   = ctrl.exmem_flush;
    assign memwb_flush   = ctrl.memwb_flush;
    assign pc_sel_branch = ctrl.pc_sel_branch;
    assign err           = err_r;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .clear (1'b0),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with a short watchdog
// (TIMEOUT=4, 16-bit counters) and one with 2-bit counters for saturation.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, mem_branch, mem_zero, mem_req, dmem_ready;

    logic        pw_a, iw_a, iff_a, idf_a, ew_a, ef_a, mf_a, psb_a, err_a;
    logic [15:0] stall_a, flush_a;
    logic        pw_s, iw_s, iff_s, idf_s, ew_s, ef_s, mf_s, psb_s, err_s;
    logic [1:0]  stall_s, flush_s;

    logic [7:0] ctrl_a, ctrl_s;
    assign ctrl_a = {pw_a, iw_a, iff_a, idf_a, ew_a, ef_a, mf_a, psb_a};
    assign ctrl_s = {pw_s, iw_s, iff_s, idf_s, ew_s, ef_s, mf_s, psb_s};

    localparam logic [7:0] C_IDLE   = 8'b0000_0000;
    localparam logic [7:0] C_NORM   = 8'b1100_1000;
    localparam logic [7:0] C_LU     = 8'b0001_1000;
    localparam logic [7:0] C_BR     = 8'b1111_1101;
    localparam logic [7:0] C_MSTALL = 8'b0000_0010;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch),
        .mem_zero(mem_zero), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_write(pw_a), .ifid_write(iw_a), .ifid_flush(iff_a),
        .idex_flush(idf_a), .exmem_write(ew_a), .exmem_flush(ef_a),
        .memwb_flush(mf_a), .pc_sel_branch(psb_a), .err(err_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a)
    );

    pipe_hazard_ctrl #(.TIMEOUT(64), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .mem_branch(mem_branch),
        .mem_zero(mem_zero), .mem_req(mem_req), .dmem_ready(dmem_ready),
        .pc_write(pw_s), .ifid_write(iw_s), .ifid_flush(iff_s),
        .idex_flush(idf_s), .exmem_write(ew_s), .exmem_flush(ef_s),
        .memwb_flush(mf_s), .pc_sel_branch(psb_s), .err(err_s),
        .stall_cnt(stall_s), .flush_cnt(flush_s)
    );

    typedef struct {
        logic [4:0]  rs, rt;
        logic        rd;
        logic [4:0]  ert;
        logic        br, z, req, rdy;
        logic [7:0]  exp_ctrl;
        logic [15:0] exp_stall, exp_flush;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt,
                                input logic rd, input logic [4:0] ert,
                                input logic br, input logic z,
                                input logic req, input logic rdy,
                                input logic [7:0] ec,
                                input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.rs = rs; v.rt = rt; v.rd = rd; v.ert = ert;
        v.br = br; v.z = z; v.req = req; v.rdy = rdy;
        v.exp_ctrl = ec; v.exp_stall = es; v.exp_flush = ef;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_in();
        id_rs = '0; id_rt = '0; ex_rt = '0; ex_mem_read = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_in();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic set_load_use();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    endtask

    initial begin
        vecs[0]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[1]  = mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'd1, 16'd0);
        vecs[2]  = mk(5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU, 16'd1, 16'd0);
        vecs[3]  = mk(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[4]  = mk(5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[5]  = mk(5'd3, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[6]  = mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, 16'd0, 16'd1);
        vecs[7]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[8]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_NORM, 16'd0, 16'd0);
        vecs[9]  = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, C_NORM, 16'd0, 16'd0);
        vecs[10] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'bx, C_NORM, 16'd0, 16'd0);
        vecs[11] = mk(5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_MSTALL, 16'd1, 16'd0);
        vecs[12] = mk(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, C_MSTALL, 16'd1, 16'd0);

        // Reset state, with a load-use pattern present on the inputs.
        clear_in();
        set_load_use();
        #2 rst = 1'b0;
        #2;
        chk("reset_ctrl_a", ctrl_a, C_IDLE);
        chk("reset_ctrl_s", ctrl_s, C_IDLE);
        chk("reset_err", err_a, 1'b0);
        chk("reset_stall", stall_a, 16'd0);
        chk("reset_flush", flush_a, 16'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single-cycle decode table, each vector from a fresh RUN state.
        for (int i = 0; i < 13; i++) begin
            do_reset();
            id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_mem_read = vecs[i].rd;
            ex_rt = vecs[i].ert; mem_branch = vecs[i].br; mem_zero = vecs[i].z;
            mem_req = vecs[i].req; dmem_ready = vecs[i].rdy;
            #1;
            chk($sformatf("vec%0d_ctrl", i), ctrl_a, vecs[i].exp_ctrl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_stall", i), stall_a, vecs[i].exp_stall);
            chk($sformatf("vec%0d_flush", i), flush_a, vecs[i].exp_flush);
        end

        // Load-use gives exactly one bubble.
        do_reset();
        set_load_use();
        #1 chk("lu_ctrl", ctrl_a, C_LU);
        @(negedge clk);
        clear_in();
        #1;
        chk("lu_next_ctrl", ctrl_a, C_NORM);
        chk("lu_stall", stall_a, 16'd1);

        // Three wait cycles then release; branch/load-use ignored while waiting.
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (c == 2) begin
                set_load_use();
                mem_branch = 1'b1; mem_zero = 1'b1;
            end
            #1 chk($sformatf("mw_ctrl%0d", c), ctrl_a, C_MSTALL);
            @(negedge clk);
            clear_in();
            mem_req = 1'b1;
        end
        dmem_ready = 1'b1;
        #1 chk("mw_release_ctrl", ctrl_a, C_NORM);
        @(negedge clk);
        clear_in();
        #1;
        chk("mw_run_ctrl", ctrl_a, C_NORM);
        chk("mw_stall", stall_a, 16'd3);
        chk("mw_flush", flush_a, 16'd0);
        chk("mw_err", err_a, 1'b0);

        // Watchdog timeout into sticky ERR.
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1 chk($sformatf("to_ctrl%0d", c), ctrl_a, C_MSTALL);
            @(posedge clk);
            #1;
            chk($sformatf("to_stall%0d", c), stall_a, 32'(c));
            chk($sformatf("to_err%0d", c), err_a, (c == 4) ? 32'd1 : 32'd0);
            @(negedge clk);
        end
        chk("err_ctrl", ctrl_a, C_IDLE);
        dmem_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("err_sticky", err_a, 1'b1);
            chk("err_ctrl_hold", ctrl_a, C_IDLE);
            chk("err_stall_hold", stall_a, 16'd4);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("err_rst_err", err_a, 1'b0);
        chk("err_rst_stall", stall_a, 16'd0);
        chk("err_rst_ctrl", ctrl_a, C_IDLE);
        rst = 1'b1;
        clear_in();
        #1 chk("err_rst_run", ctrl_a, C_NORM);

        // Reset asserted mid-MEM_WAIT returns to RUN.
        do_reset();
        mem_req = 1'b1; dmem_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1 chk("mwr_wait_ctrl", ctrl_a, C_MSTALL);
        rst = 1'b0;
        #1 chk("mwr_rst_ctrl", ctrl_a, C_IDLE);
        rst = 1'b1;
        clear_in();
        #1;
        chk("mwr_run_ctrl", ctrl_a, C_NORM);
        chk("mwr_stall", stall_a, 16'd0);

        // Saturation of 2-bit counters.
        do_reset();
        set_load_use();
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("sat_stall%0d", c), stall_s, (c < 3) ? 32'(c) : 32'd3);
        end
        @(negedge clk);
        clear_in();
        mem_branch = 1'b1; mem_zero = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            #1 chk($sformatf("sat_br_ctrl%0d", c), ctrl_s, C_BR);
            @(posedge clk);
            #1;
            chk($sformatf("sat_flush%0d", c), flush_s, (c < 3) ? 32'(c) : 32'd3);
            @(negedge clk);
        end
        chk("sat_stall_hold", stall_s, 2'd3);
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
